// File: rtl/dds_pkg.sv
// Shared DDS definitions: mode encodings, default widths and the mode-switch FSM state.
package dds_pkg;

  localparam int DDS_PHASE_W = 24;
  localparam int DDS_ADDR_W  = 11;
  localparam int DDS_MODE_W  = 3;

  localparam int MODE_RAMP  = 0;
  localparam int MODE_QSINE = 1;
  localparam int MODE_TRI   = 2;
  localparam int MODE_SQR   = 3;
  localparam int MODE_RRAMP = 4;

  typedef enum logic {
    STEADY  = 1'b0,
    PENDING = 1'b1
  } mode_st_e;

endpackage

// File: rtl/dds_addr_fold.sv
// Maps an offset phase onto a waveform table address for the selected mode.
// Combinational, zero latency; no flow control.
module dds_addr_fold
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W,
  parameter int MODE_W = DDS_MODE_W
) (
  input  logic [ADDR_W-1:0] phase,
  input  logic [MODE_W-1:0] mode,
  output logic [ADDR_W-1:0] addr,
  output logic              sign
);

  logic [ADDR_W-3:0] q_idx;
  logic [ADDR_W-1:0] tri_ramp;

  // quadrants 1 and 3 have bit ADDR_W-2 set and read the quarter table backwards
  assign q_idx    = phase[ADDR_W-2] ? ~phase[ADDR_W-3:0] : phase[ADDR_W-3:0];
  assign tri_ramp = {phase[ADDR_W-2:0], 1'b0};

  always_comb begin
    addr = '0;
    sign = 1'b0;
    case (int'(mode))
      MODE_RAMP:  addr = phase;
      MODE_QSINE: begin
        addr = {2'b00, q_idx};
        sign = phase[ADDR_W-1];
      end
      MODE_TRI:   addr = phase[ADDR_W-1] ? ~tri_ramp : tri_ramp;
      MODE_SQR:   addr = {ADDR_W{phase[ADDR_W-1]}};
      MODE_RRAMP: addr = ~phase;
      default:    addr = '0;
    endcase
  end

endmodule

// File: rtl/dds_phase_mapper.sv
// Phase accumulator plus table-address mapper with wrap-aligned mode switching.
// Latency 2 cycles (accumulate/offset, then map); no backpressure, en_i gates sample flow.
module dds_phase_mapper
  import dds_pkg::*;
#(
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int ADDR_W  = DDS_ADDR_W,
  parameter int MODE_W  = DDS_MODE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] Fword_i,
  input  logic [ADDR_W-1:0]  Phase_off_i,
  input  logic [MODE_W-1:0]  Mode_i,
  input  logic               Mode_ld_i,
  output logic [ADDR_W-1:0]  Address_o,
  output logic               Sign_o,
  output logic               Valid_o,
  output logic               Wrap_o,
  output logic [MODE_W-1:0]  Mode_o
);

  logic [PHASE_W-1:0] acc;
  logic               carry_q;
  logic [PHASE_W:0]   acc_sum;
  logic               wrap_now;

  mode_st_e           st_q, st_d;
  logic [MODE_W-1:0]  pend_q, pend_d;
  logic [MODE_W-1:0]  act_q, act_d;
  logic [MODE_W-1:0]  smp_mode;

  logic               s1_vld, s1_wrap;
  logic [ADDR_W-1:0]  s1_phase;
  logic [MODE_W-1:0]  s1_mode;
  logic [ADDR_W-1:0]  fold_addr;
  logic               fold_sign;

  assign acc_sum  = {1'b0, acc} + {1'b0, Fword_i};
  // the sample taken right after a carrying update is the wrap sample
  assign wrap_now = en_i & carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (en_i) begin
      acc     <= acc_sum[PHASE_W-1:0];
      carry_q <= acc_sum[PHASE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= STEADY;
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    act_d  = act_q;
    if (Mode_ld_i && wrap_now) begin
      act_d = Mode_i;
      st_d  = STEADY;
    end else if (Mode_ld_i) begin
      pend_d = Mode_i;
      st_d   = PENDING;
    end else if (st_q == PENDING && (wrap_now || !en_i)) begin
      act_d = pend_q;
      st_d  = STEADY;
    end
  end

  // mode tagged onto the sample launched this cycle, so a switch lands exactly on the wrap sample
  always_comb begin
    smp_mode = act_q;
    if (Mode_ld_i && wrap_now) begin
      smp_mode = Mode_i;
    end else if (st_q == PENDING && wrap_now) begin
      smp_mode = pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_wrap  <= 1'b0;
      s1_phase <= '0;
      s1_mode  <= '0;
    end else begin
      s1_vld  <= en_i;
      s1_wrap <= wrap_now;
      if (en_i) begin
        s1_phase <= acc[PHASE_W-1 -: ADDR_W] + Phase_off_i;
        s1_mode  <= smp_mode;
      end
    end
  end

  dds_addr_fold #(
    .ADDR_W (ADDR_W),
    .MODE_W (MODE_W)
  ) u_fold (
    .phase (s1_phase),
    .mode  (s1_mode),
    .addr  (fold_addr),
    .sign  (fold_sign)
  );

  // sample outputs hold across en_i gaps; Mode_o moves only with a freshly mapped sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Address_o <= '0;
      Sign_o    <= 1'b0;
      Valid_o   <= 1'b0;
      Wrap_o    <= 1'b0;
      Mode_o    <= '0;
    end else begin
      Valid_o <= s1_vld;
      Wrap_o  <= s1_wrap;
      if (s1_vld) begin
        Address_o <= fold_addr;
        Sign_o    <= fold_sign;
        Mode_o    <= s1_mode;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_mapper.sv
// Bench for dds_phase_mapper: directed scenarios plus randomized traffic against a
// sample-queue reference model built from accumulator arithmetic and the mode rules.
module tb_dds_phase_mapper;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic [23:0] Fword_i;
  logic [10:0] Phase_off_i;
  logic [2:0]  Mode_i;
  logic        Mode_ld_i;
  logic [10:0] Address_o;
  logic        Sign_o;
  logic        Valid_o;
  logic        Wrap_o;
  logic [2:0]  Mode_o;

  dds_phase_mapper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .Fword_i     (Fword_i),
    .Phase_off_i (Phase_off_i),
    .Mode_i      (Mode_i),
    .Mode_ld_i   (Mode_ld_i),
    .Address_o   (Address_o),
    .Sign_o      (Sign_o),
    .Valid_o     (Valid_o),
    .Wrap_o      (Wrap_o),
    .Mode_o      (Mode_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int due;
    int addr;
    bit sign;
    bit wrap;
    int mode;
  } smp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  longint      m_acc;
  bit          m_carry;
  int          m_act;
  bit          m_pend;
  int          m_pval;
  smp_t        q[$];
  logic [10:0] exp_addr;
  logic        exp_sign, exp_vld, exp_wrap;
  logic [2:0]  exp_mode;

  function automatic int ref_addr(int m, int p);
    case (m)
      0:       return p;
      1:       return ((p / 512) % 2 == 1) ? 511 - (p % 512) : (p % 512);
      2:       return (p < 1024) ? 2 * p : 2047 - 2 * (p - 1024);
      3:       return (p >= 1024) ? 2047 : 0;
      4:       return 2047 - p;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_sign(int m, int p);
    return (m == 1) && (p >= 1024);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_carry = 0; m_act = 0; m_pend = 0; m_pval = 0;
    q.delete();
    exp_addr = '0; exp_sign = 0; exp_vld = 0; exp_wrap = 0; exp_mode = '0;
  endtask

  // Drives one cycle, advances the reference model and leaves the expected outputs in exp_*.
  task automatic step(input bit en, input bit ld, input int mi);
    bit     ws;
    int     m, p;
    longint nxt;
    smp_t   s;
    en_i = en; Mode_ld_i = ld; Mode_i = 3'(mi);
    ws = en && m_carry;
    if (ld && ws)          m = mi;
    else if (m_pend && ws) m = m_pval;
    else                   m = m_act;
    if (en) begin
      p = int'(((m_acc >> 13) + longint'(Phase_off_i)) % 2048);
      s.due = cyc + 2; s.addr = ref_addr(m, p); s.sign = ref_sign(m, p);
      s.wrap = ws; s.mode = m;
      q.push_back(s);
      nxt = m_acc + longint'(Fword_i);
      m_carry = (nxt >= 64'd16777216);
      m_acc = nxt % 64'd16777216;
    end
    if (ld && ws) begin
      m_act = mi; m_pend = 0;
    end else if (ld) begin
      m_pval = mi; m_pend = 1;
    end else if (m_pend && (ws || !en)) begin
      m_act = m_pval; m_pend = 0;
    end
    @(posedge clk); #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      s = q.pop_front();
      exp_vld = 1; exp_wrap = s.wrap; exp_addr = 11'(s.addr);
      exp_sign = s.sign; exp_mode = 3'(s.mode);
    end else begin
      exp_vld = 0; exp_wrap = 0;
    end
  endtask

  task automatic reset_dut();
    en_i = 0; Mode_ld_i = 0; rst_n = 0;
    #2;
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; en_i = 1; Fword_i = 24'h002000; Phase_off_i = 11'd5;
    Mode_i = 3'd4; Mode_ld_i = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tests += 5;
    if (Address_o !== 11'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", Address_o); end
    if (Sign_o !== 1'b0)     begin n_fail++; $display("FAIL reset_sign got %b want 0", Sign_o); end
    if (Valid_o !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", Valid_o); end
    if (Wrap_o !== 1'b0)     begin n_fail++; $display("FAIL reset_wrap got %b want 0", Wrap_o); end
    if (Mode_o !== 3'd0)     begin n_fail++; $display("FAIL reset_mode got %0d want 0", Mode_o); end
    Phase_off_i = 0;
    reset_dut();
    step(0, 0, 0);
    n_tests++;
    if (Valid_o !== 1'b0 || Address_o !== 11'd0) begin
      n_fail++; $display("FAIL reset_idle vld/addr got %b/%0d want 0/0", Valid_o, Address_o);
    end
    step(1, 0, 0);
    n_tests++;
    if (Valid_o !== 1'b0) begin n_fail++; $display("FAIL first_valid_early got %b want 0", Valid_o); end
    step(1, 0, 0);
    n_tests++;
    if (Valid_o !== 1'b1 || Address_o !== 11'd0) begin
      n_fail++; $display("FAIL first_valid vld/addr got %b/%0d want 1/0", Valid_o, Address_o);
    end
  endtask

  task automatic test_ramp();
    reset_dut();
    Fword_i = 24'h002000; Phase_off_i = 0;
    for (int j = 1; j <= 2052; j++) begin
      step(1, 0, 0);
      n_tests++;
      if (Valid_o !== exp_vld || Address_o !== exp_addr || Wrap_o !== exp_wrap) begin
        n_fail++;
        $display("FAIL ramp c%0d vld/addr/wrap got %b/%0d/%b want %b/%0d/%b",
                 j, Valid_o, Address_o, Wrap_o, exp_vld, exp_addr, exp_wrap);
      end
      if (j == 2 || j == 2050) begin
        n_tests++;
        if (Address_o !== 11'd0 || Wrap_o !== (j == 2050)) begin
          n_fail++; $display("FAIL ramp_zero c%0d addr/wrap got %0d/%b", j, Address_o, Wrap_o);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    reset_dut();
    Fword_i = 24'h002000; Phase_off_i = 0;
    for (int j = 1; j <= 2052; j++) begin
      step(1, j == 101, 4);
      n_tests++;
      if (Address_o !== exp_addr || Mode_o !== exp_mode || Wrap_o !== exp_wrap ||
          (j >= 2 && Valid_o !== 1'b1)) begin
        n_fail++;
        $display("FAIL switch c%0d vld/addr/mode got %b/%0d/%0d want 1/%0d/%0d",
                 j, Valid_o, Address_o, Mode_o, exp_addr, exp_mode);
      end
      if (j == 2049) begin
        n_tests++;
        if (Address_o !== 11'd2047 || Mode_o !== 3'd0) begin
          n_fail++; $display("FAIL switch_pre addr/mode got %0d/%0d want 2047/0", Address_o, Mode_o);
        end
      end
      if (j == 2050) begin
        n_tests++;
        if (Address_o !== 11'd2047 || Mode_o !== 3'd4 || Wrap_o !== 1'b1) begin
          n_fail++;
          $display("FAIL switch_post addr/mode/wrap got %0d/%0d/%b want 2047/4/1", Address_o, Mode_o, Wrap_o);
        end
      end
    end
  endtask

  task automatic test_double_load();
    reset_dut();
    Fword_i = 24'h002000; Phase_off_i = 0;
    for (int j = 1; j <= 4100; j++) begin
      step(1, (j == 500) || (j == 900) || (j == 4097), (j == 500) ? 3 : (j == 900) ? 4 : 2);
      n_tests++;
      if (Address_o !== exp_addr || Mode_o !== exp_mode || Mode_o === 3'd3) begin
        n_fail++;
        $display("FAIL dbl_load c%0d addr/mode got %0d/%0d want %0d/%0d", j, Address_o, Mode_o, exp_addr, exp_mode);
      end
      if (j == 2050 || j == 4098 || j == 4099) begin
        n_tests++;
        if ((j == 2050 && (Address_o !== 11'd2047 || Mode_o !== 3'd4)) ||
            (j == 4098 && (Address_o !== 11'd0 || Mode_o !== 3'd2 || Wrap_o !== 1'b1)) ||
            (j == 4099 && (Address_o !== 11'd2 || Mode_o !== 3'd2))) begin
          n_fail++; $display("FAIL dbl_load_pt c%0d addr/mode/wrap got %0d/%0d/%b", j, Address_o, Mode_o, Wrap_o);
        end
      end
    end
  endtask

  task automatic test_offset();
    reset_dut();
    Fword_i = 24'h002000; Phase_off_i = 11'd1024;
    for (int j = 1; j <= 1030; j++) begin
      step(1, 0, 0);
      n_tests++;
      if (Valid_o !== exp_vld || Address_o !== exp_addr) begin
        n_fail++; $display("FAIL offset c%0d addr got %0d want %0d", j, Address_o, exp_addr);
      end
      if (j == 2 || j == 1025 || j == 1026) begin
        n_tests++;
        if (Address_o !== ((j == 2) ? 11'd1024 : (j == 1025) ? 11'd2047 : 11'd0)) begin
          n_fail++; $display("FAIL offset_pt c%0d addr got %0d", j, Address_o);
        end
      end
    end
  endtask

  task automatic test_fold_points();
    int fm[11] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 0};
    int fp[11] = '{511, 512, 1024, 1536, 1023, 1024, 1023, 1024, 100, 700, 1234};
    int fa[11] = '{511, 511, 0, 511, 2046, 2047, 0, 2047, 1947, 0, 1234};
    bit fs[11] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    reset_dut();
    Fword_i = 24'h002000;
    for (int k = 0; k < 11; k++) begin
      step(0, 1, fm[k]);
      step(0, 0, 0);
      Phase_off_i = 11'((fp[k] - int'(m_acc >> 13) + 2048) % 2048);
      step(1, 0, 0);
      step(0, 0, 0);
      n_tests++;
      if (Valid_o !== 1'b1 || Address_o !== 11'(fa[k]) || Sign_o !== fs[k] || Mode_o !== 3'(fm[k]) ||
          Address_o !== exp_addr) begin
        n_fail++;
        $display("FAIL fold m%0d p%0d addr/sign/mode got %0d/%b/%0d want %0d/%b/%0d",
                 fm[k], fp[k], Address_o, Sign_o, Mode_o, fa[k], fs[k], fm[k]);
      end
    end
  endtask

  task automatic test_zero_fword();
    reset_dut();
    Fword_i = 0; Phase_off_i = 11'd77;
    for (int j = 1; j <= 300; j++) begin
      step(1, $urandom_range(0, 15) == 0, $urandom_range(0, 7));
      n_tests++;
      if (Wrap_o !== 1'b0 || Address_o !== exp_addr || Mode_o !== exp_mode) begin
        n_fail++; $display("FAIL zero_fword c%0d wrap/addr got %b/%0d want 0/%0d", j, Wrap_o, Address_o, exp_addr);
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int j = 0; j < 3000; j++) begin
      if (j % 250 == 0) begin
        Fword_i = 24'($urandom_range(1, 1 << 20));
        Phase_off_i = 11'($urandom_range(0, 2047));
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 7));
      n_tests++;
      if (Valid_o !== exp_vld || Wrap_o !== exp_wrap || Address_o !== exp_addr ||
          Sign_o !== exp_sign || Mode_o !== exp_mode) begin
        n_fail++;
        $display("FAIL random c%0d vld/wrap/addr/sign/mode got %b/%b/%0d/%b/%0d want %b/%b/%0d/%b/%0d",
                 j, Valid_o, Wrap_o, Address_o, Sign_o, Mode_o, exp_vld, exp_wrap, exp_addr, exp_sign, exp_mode);
      end
    end
  endtask

  task automatic test_reset_midrun();
    Fword_i = 24'h012345; Phase_off_i = 11'd300;
    for (int j = 0; j < 60; j++) step(1, j == 3, 1);
    rst_n = 0;
    #1;
    n_tests++;
    if (Address_o !== 11'd0 || Sign_o !== 1'b0 || Valid_o !== 1'b0 || Wrap_o !== 1'b0 || Mode_o !== 3'd0) begin
      n_fail++;
      $display("FAIL midrun_reset addr/sign/vld/wrap/mode got %0d/%b/%b/%b/%0d want all 0",
               Address_o, Sign_o, Valid_o, Wrap_o, Mode_o);
    end
    model_reset();
    Phase_off_i = 0;
    #1;
    rst_n = 1;
    step(1, 0, 0);
    step(1, 0, 0);
    n_tests++;
    if (Valid_o !== 1'b1 || Address_o !== 11'd0 || Mode_o !== 3'd0) begin
      n_fail++; $display("FAIL midrun_restart vld/addr/mode got %b/%0d/%0d want 1/0/0", Valid_o, Address_o, Mode_o);
    end
  endtask

  initial begin
    rst_n = 0; en_i = 0; Fword_i = 0; Phase_off_i = 0; Mode_i = 0; Mode_ld_i = 0;
    model_reset();
    test_reset();
    test_ramp();
    test_mode_switch();
    test_double_load();
    test_offset();
    test_fold_points();
    test_zero_fword();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
